wb_byte_initiator: RTL and testbench

Single-outstanding Wishbone classic initiator for the 8-bit peripheral bus. It turns byte read/write commands from a valid/ready command port into single Wishbone cycles on the bus that serves the GPIO and other byte-wide slaves. It handles ack, err and rty terminations with a bounded retry count and a no-response timeout, then returns one response pulse per command. Intended users are the debug/bring-up sequencer and the boot-time pin configurator.

---
 rtl/wb_byte_initiator_if.sv | 27 ++
 rtl/wb_byte_initiator.sv | 144 ++++++++++++++
 tb/tb_wb_byte_initiator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_byte_initiator_if.sv
// Wishbone classic byte bus between the initiator (master) and a byte-wide slave.
interface wb_byte_initiator_if #(
    parameter int wb_dat_width = 8,
    parameter int wb_adr_width = 3
);
    logic [wb_adr_width-1:0] adr;
    logic [wb_dat_width-1:0] dat_w;
    logic [wb_dat_width-1:0] dat_r;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (
        output adr, dat_w, we, cyc, stb, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, we, cyc, stb, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_byte_initiator.sv
// Single-outstanding Wishbone classic initiator: one byte command in, one bus
// cycle (with rty re-issue and no-response timeout) out, one response pulse back.
module wb_byte_initiator #(
    parameter int wb_dat_width   = 8,
    parameter int wb_adr_width   = 3,
    parameter int timeout_cycles = 255,
    parameter int rty_limit      = 3
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [wb_adr_width-1:0] cmd_adr_i,
    input  logic [wb_dat_width-1:0] cmd_dat_i,
    output logic                    rsp_valid_o,
    output logic [wb_dat_width-1:0] rsp_dat_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    wb_byte_initiator_if.master     wb
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUS     = 2'd1;
    localparam logic [1:0] S_BACKOFF = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(timeout_cycles - 1);
    localparam logic [2:0] RTY_MAX  = 3'(rty_limit);

    logic [1:0]              state_q, state_d;
    logic                    we_q, we_d;
    logic [wb_adr_width-1:0] adr_q, adr_d;
    logic [wb_dat_width-1:0] dat_q, dat_d;
    logic [7:0]              tmo_q, tmo_d;
    logic [2:0]              rty_q, rty_d;
    logic [wb_dat_width-1:0] rsp_dat_q, rsp_dat_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_tmo_q, rsp_tmo_d;
    logic                    cyc_q, rdy_q, rsp_vld_q;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        tmo_d     = tmo_q;
        rty_d     = rty_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        rsp_tmo_d = rsp_tmo_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    tmo_d   = '0;
                    rty_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // err > ack > rty; any termination beats a coincident timeout
                if (wb.err) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b0;
                    state_d   = S_RESP;
                end else if (wb.ack) begin
                    rsp_dat_d = we_q ? '0 : wb.dat_r;
                    rsp_err_d = 1'b0;
                    rsp_tmo_d = 1'b0;
                    state_d   = S_RESP;
                end else if (wb.rty) begin
                    if (rty_q < RTY_MAX) begin
                        rty_d   = rty_q + 3'd1;
                        state_d = S_BACKOFF;
                    end else begin
                        rsp_dat_d = '0;
                        rsp_err_d = 1'b1;
                        rsp_tmo_d = 1'b0;
                        state_d   = S_RESP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_BACKOFF: begin
                tmo_d   = '0;
                state_d = S_BUS;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            tmo_q     <= '0;
            rty_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_tmo_q <= 1'b0;
            cyc_q     <= 1'b0;
            rdy_q     <= 1'b1;
            rsp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            tmo_q     <= tmo_d;
            rty_q     <= rty_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            rsp_tmo_q <= rsp_tmo_d;
            cyc_q     <= (state_d == S_BUS);
            rdy_q     <= (state_d == S_IDLE);
            rsp_vld_q <= (state_d == S_RESP);
        end
    end

    assign cmd_ready_o   = rdy_q;
    assign rsp_valid_o   = rsp_vld_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_tmo_q;

    assign wb.adr   = adr_q;
    assign wb.dat_w = dat_q;
    assign wb.we    = we_q;
    assign wb.cyc   = cyc_q;
    assign wb.stb   = cyc_q;
    assign wb.cti   = 3'b000;
    assign wb.bte   = 2'b00;
endmodule

// File: tb/tb_wb_byte_initiator.sv
// Directed bench for wb_byte_initiator against a configurable byte slave model.
module tb_wb_byte_initiator;
    localparam int M_GPIO = 0;
    localparam int M_ERR  = 1;
    localparam int M_NONE = 2;
    localparam int M_RTY2 = 3;
    localparam int M_RTYF = 4;
    localparam int M_BOTH = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_we = 1'b0;
    logic [2:0] cmd_adr = '0;
    logic [7:0] cmd_dat = '0;
    logic       cmd_ready_o;
    logic       rsp_valid_o;
    logic [7:0] rsp_dat_o;
    logic       rsp_err_o;
    logic       rsp_timeout_o;

    int checks = 0;
    int failures = 0;
    int mode = M_GPIO;

    int         r_lat, r_stb, r_gap;
    logic [7:0] r_dat;
    logic       r_err, r_tmo, r_cyc;

    logic [7:0] mem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    int         att = 0;

    wb_byte_initiator_if #(.wb_dat_width(8), .wb_adr_width(3)) bus ();

    wb_byte_initiator #(
        .wb_dat_width  (8),
        .wb_adr_width  (3),
        .timeout_cycles(16),
        .rty_limit     (3)
    ) dut (
        .wb_clk       (clk),
        .wb_rst       (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we),
        .cmd_adr_i    (cmd_adr),
        .cmd_dat_i    (cmd_dat),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_dat_o    (rsp_dat_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .wb           (bus.master)
    );

    always #5 clk = ~clk;

    // Slave model: registered termination one cycle after stb is seen.
    always @(posedge clk) begin
        if (rst) begin
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.rty   <= 1'b0;
            bus.dat_r <= 8'h00;
            att       <= 0;
        end else begin
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
            bus.rty <= 1'b0;
            if (bus.cyc && bus.stb && !(bus.ack || bus.err || bus.rty)) begin
                case (mode)
                    M_GPIO: begin
                        bus.ack   <= 1'b1;
                        bus.dat_r <= mem[bus.adr];
                        if (bus.we) mem[bus.adr] <= bus.dat_w;
                    end
                    M_ERR:  bus.err <= 1'b1;
                    M_RTY2: begin
                        if (att < 2) begin
                            bus.rty <= 1'b1;
                            att     <= att + 1;
                        end else begin
                            bus.ack   <= 1'b1;
                            bus.dat_r <= 8'h3C;
                        end
                    end
                    M_RTYF: bus.rty <= 1'b1;
                    M_BOTH: begin
                        bus.ack   <= 1'b1;
                        bus.err   <= 1'b1;
                        bus.dat_r <= 8'hFF;
                    end
                    default: ;
                endcase
            end
            if (rsp_valid_o) att <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic we, input logic [2:0] adr, input logic [7:0] dat);
        logic done;
        check("ready_before_accept", 32'(cmd_ready_o), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cyc_after_accept", 32'(bus.cyc), 32'd1);
        r_stb = 0;
        r_gap = 0;
        r_lat = 0;
        done  = 1'b0;
        for (int n = 1; n <= 300 && !done; n++) begin
            if (rsp_valid_o) begin
                done  = 1'b1;
                r_lat = n;
                r_dat = rsp_dat_o;
                r_err = rsp_err_o;
                r_tmo = rsp_timeout_o;
                r_cyc = bus.cyc;
            end else begin
                r_stb += int'(bus.stb);
                r_gap += int'(!bus.cyc);
                @(posedge clk); #1;
            end
        end
        check("rsp_within_bound", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    logic [2:0] radr [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd1};
    logic [7:0] rexp [10] = '{8'h10, 8'h11, 8'h12, 8'hA5, 8'h14, 8'h15, 8'h16, 8'h17, 8'hA5, 8'h11};

    initial begin
        int   seen, nacc, nrsp, last_acc, mingap;
        logic acc;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_cyc", 32'(bus.cyc), 32'd0);
        check("rst_stb", 32'(bus.stb), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        check("rst_rsp_tmo", 32'(rsp_timeout_o), 32'd0);
        check("rst_rsp_dat", 32'(rsp_dat_o), 32'd0);
        check("rst_adr", 32'(bus.adr), 32'd0);
        check("rst_dat", 32'(bus.dat_w), 32'd0);
        check("cti", 32'(bus.cti), 32'd0);
        check("bte", 32'(bus.bte), 32'd0);

        mode = M_GPIO;
        run_cmd(1'b1, 3'd3, 8'hA5);
        check("wr_lat", r_lat, 3);
        check("wr_dat", 32'(r_dat), 32'h00);
        check("wr_err", 32'(r_err), 32'd0);
        run_cmd(1'b0, 3'd3, 8'h00);
        check("rd_lat", r_lat, 3);
        check("rd_dat", 32'(r_dat), 32'hA5);
        check("rd_err", 32'(r_err), 32'd0);
        check("rd_cyc_in_resp", 32'(r_cyc), 32'd0);

        mode = M_ERR;
        run_cmd(1'b0, 3'd2, 8'h00);
        check("err_lat", r_lat, 3);
        check("err_stb_cycles", r_stb, 2);
        check("err_err", 32'(r_err), 32'd1);
        check("err_tmo", 32'(r_tmo), 32'd0);
        check("err_cyc_dropped", 32'(r_cyc), 32'd0);

        mode = M_NONE;
        run_cmd(1'b0, 3'd1, 8'h00);
        check("tmo_stb_cycles", r_stb, 16);
        check("tmo_lat", r_lat, 17);
        check("tmo_err", 32'(r_err), 32'd1);
        check("tmo_tmo", 32'(r_tmo), 32'd1);
        check("tmo_dat", 32'(r_dat), 32'h00);

        mode = M_RTY2;
        run_cmd(1'b0, 3'd4, 8'h00);
        check("rty2_gaps", r_gap, 2);
        check("rty2_stb_cycles", r_stb, 6);
        check("rty2_lat", r_lat, 9);
        check("rty2_dat", 32'(r_dat), 32'h3C);
        check("rty2_err", 32'(r_err), 32'd0);

        mode = M_RTYF;
        run_cmd(1'b0, 3'd4, 8'h00);
        check("rtyf_attempts", r_gap + 1, 4);
        check("rtyf_stb_cycles", r_stb, 8);
        check("rtyf_lat", r_lat, 12);
        check("rtyf_err", 32'(r_err), 32'd1);
        check("rtyf_tmo", 32'(r_tmo), 32'd0);

        mode = M_BOTH;
        run_cmd(1'b0, 3'd0, 8'h00);
        check("both_err", 32'(r_err), 32'd1);
        check("both_tmo", 32'(r_tmo), 32'd0);
        check("both_dat", 32'(r_dat), 32'h00);

        mode = M_NONE;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 3'd5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mid_cyc_before_rst", 32'(bus.cyc), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_cyc", 32'(bus.cyc), 32'd0);
        check("mid_rst_stb", 32'(bus.stb), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        rst = 1'b0;
        check("mid_rst_ready", 32'(cmd_ready_o), 32'd1);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            seen += int'(rsp_valid_o);
        end
        check("mid_rst_no_rsp", seen, 0);

        mode = M_GPIO;
        run_cmd(1'b0, 3'd3, 8'h00);
        check("post_rst_lat", r_lat, 3);
        check("post_rst_dat", 32'(r_dat), 32'hA5);

        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = radr[0];
        nacc      = 0;
        nrsp      = 0;
        last_acc  = 0;
        mingap    = 1000;
        for (int c = 0; c < 200 && nrsp < 10; c++) begin
            acc = cmd_valid && cmd_ready_o;
            @(posedge clk); #1;
            if (acc) begin
                if (nacc > 0 && (c - last_acc) < mingap) mingap = c - last_acc;
                last_acc = c;
                nacc++;
                check("b2b_ready_low_in_bus", 32'(cmd_ready_o), 32'd0);
                if (nacc == 10) cmd_valid = 1'b0;
                else cmd_adr = radr[nacc];
            end
            if (rsp_valid_o && nrsp < 10) begin
                check("b2b_dat", 32'(rsp_dat_o), 32'(rexp[nrsp]));
                nrsp++;
            end
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", nacc, 10);
        check("b2b_responses", nrsp, 10);
        check("b2b_min_spacing", mingap, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
